weight_loader: RTL and testbench
================================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter ROWS, default 10, number of weight rows (neurons).
REQ-002 Parameter COLS, default 10, bits per weight row.
REQ-003 Parameter ADDR_W, default 5, row-address width, at least clog2(ROWS).
REQ-004 Clock  in  1  sole clock; all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 WE  in  1  bit-strobe; when high, In is sampled this cycle.
REQ-007 In  in  1  serial weight bit.
REQ-008 address  in  ADDR_W  target row, latched with the first bit of a row.
REQ-009 Clear  in  1  request to zero all rows.
REQ-010 rd_addr  in  ADDR_W  read-port row select.
REQ-011 rd_data  out  COLS  registered row read; bit c = W[rd_addr][c].
REQ-012 weight  out  ROWS*COLS  flattened matrix; bit r*COLS+c = W[r][c].
REQ-013 loaded  out  ROWS  bit r set once row r has been committed since the last clear.
REQ-014 busy  out  1  high in SHIFT, COMMIT and CLEAR.
REQ-015 row_done  out  1  one-cycle pulse on every commit attempt.
REQ-016 err  out  1  one-cycle pulse when a committed row's latched address is at least ROWS.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, COMMIT and CLEAR.
REQ-018 IDLE with Clear=1 SHALL go to CLEAR with row counter 0; Clear has priority over WE.
REQ-019 IDLE with WE=1 and Clear=0 SHALL store In at column 0, latch address, set the bit count to 1, and go to SHIFT; if COLS==1 it SHALL go directly to COMMIT.
REQ-020 SHIFT with WE=1 SHALL store In at column count and increment the count; when the count reaches COLS it SHALL go to COMMIT.
REQ-021 SHIFT with WE=0 SHALL hold all state; gaps between bits are unlimited.
REQ-022 SHIFT with Clear=1 SHALL abort the partial row (no write) and go to CLEAR.
REQ-023 COMMIT SHALL last exactly one cycle and then return to IDLE.
  - Always pulses row_done.
  - Address in range: writes the row buffer to W[addr] and sets loaded[addr].
  - Address out of range: discards the row, leaves W unchanged, pulses err.
REQ-024 CLEAR SHALL zero one row per cycle (row counter 0..ROWS-1) and clear that row's loaded bit; after row ROWS-1 it SHALL return to IDLE (ROWS cycles total).
REQ-025 WE and In SHALL be ignored in COMMIT and CLEAR, and Clear SHALL be ignored in COMMIT and CLEAR.
REQ-026 The weight outputs SHALL reflect a write on the cycle after the COMMIT edge; there are no partial-row updates.
REQ-027 rd_data SHALL have 1-cycle latency, sampled from the registered matrix.
  - Out-of-range rd_addr returns 0.
  - A same-cycle commit to the same row returns the old value.
REQ-028 The bit count SHALL be ceil(log2(COLS+1)) wide and SHALL never wrap; it resets to 0 on every entry to IDLE.

Reset
REQ-029 Reset=1 SHALL force the following on the next edge, overriding all other inputs including mid-SHIFT and mid-CLEAR:
  - FSM to IDLE.
  - All of W, loaded, rd_data, the row buffer and the counters to 0.
  - busy, row_done and err to 0.
REQ-030 Reset SHALL NOT depend on any asynchronous path.

Structure
REQ-031 A shared package weight_pkg SHALL hold the FSM state enum and the default ROWS/COLS constants.
REQ-032 The serial row buffer and its bit counter SHALL be one sub-module, weight_shift_row (parameter COLS; outputs row and full).
REQ-033 The matrix SHALL be plain flops, not inferred RAM, so that all rows are visible on weight.

Verification (ROWS=10, COLS=10)
REQ-034 Reset, then WE=1 for 10 cycles with In=1 and address=0 -> COMMIT pulse, W[0]=10'b1111111111, loaded=10'b0000000001, busy low after 11 cycles.
REQ-035 Load 1010101010 (first bit first) to address 9, with WE low for 3 cycles after bit 4 -> W[9]=1010101010, bit 90=1, row_done pulses once, no early commit.
REQ-036 Load a row to address 20 -> err pulse, W unchanged, loaded unchanged.
REQ-037 Load rows 0 and 3, then Clear=1 -> busy high for 10 cycles, W all 0, loaded=0; WE during CLEAR is ignored.
REQ-038 Assert Reset after 5 bits of a row, then load a fresh row to address 2 -> only the new 10 bits appear in W[2] and the count restarts at 0.
REQ-039 rd_addr=9 after REQ-035 -> rd_data=1010101010 one cycle later; rd_addr=12 -> 0.

Source files
------------

// File: rtl/weight_pkg.sv
// weight_pkg: shared definitions for the serial weight loader.
//   state_e  - loader FSM states
//   ROWS_DEF - default number of weight rows (neurons)
//   COLS_DEF - default bits per weight row
package weight_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    CLEAR  = 2'd3
  } state_e;

  localparam int ROWS_DEF = 10;
  localparam int COLS_DEF = 10;

endpackage

// File: rtl/weight_loader_if.sv
// weight_loader_if: bus between a host and the weight loader.
//   WE/In/address - serial bit strobe, data bit, target row (latched on first bit)
//   Clear         - zero all rows
//   rd_addr       - read-port row select
//   rd_data       - registered row read
//   weight        - flattened matrix, bit r*COLS+c = W[r][c]
//   loaded        - per-row committed flags
//   busy/row_done/err - status
interface weight_loader_if #(
  parameter int ROWS   = 10,
  parameter int COLS   = 10,
  parameter int ADDR_W = 5
);
  logic                 WE;
  logic                 In;
  logic [ADDR_W-1:0]    address;
  logic                 Clear;
  logic [ADDR_W-1:0]    rd_addr;
  logic [COLS-1:0]      rd_data;
  logic [ROWS*COLS-1:0] weight;
  logic [ROWS-1:0]      loaded;
  logic                 busy;
  logic                 row_done;
  logic                 err;

  modport master (
    output WE, In, address, Clear, rd_addr,
    input  rd_data, weight, loaded, busy, row_done, err
  );

  modport slave (
    input  WE, In, address, Clear, rd_addr,
    output rd_data, weight, loaded, busy, row_done, err
  );
endinterface

// File: rtl/weight_shift_row.sv
// weight_shift_row: serial row buffer plus bit counter.
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   clr_i  - return the bit counter to 0
//   en_i   - store bit_i at column <count> and advance the count
//   bit_i  - serial data bit
//   row_o  - assembled row, bit c = c-th bit received
//   full_o - the next accepted bit completes the row (count == COLS-1)
module weight_shift_row
  import weight_pkg::*;
#(
  parameter int COLS = COLS_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            bit_i,
  output logic [COLS-1:0] row_o,
  output logic            full_o
);
  localparam int CW = $clog2(COLS + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [COLS-1:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (32'(cnt_q) < COLS)) begin
      // Count saturates at COLS; the FSM commits before that can matter.
      for (int c = 0; c < COLS; c++)
        if (32'(cnt_q) == c) row_d[c] = bit_i;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  // Look-ahead form keeps the FSM able to jump to COMMIT on the last bit
  // without a combinational path back through en_i.
  assign full_o = (32'(cnt_q) == COLS - 1);
  assign row_o  = row_q;

endmodule

// File: rtl/weight_loader.sv
// weight_loader: serially loads weight rows into a flop-based ROWSxCOLS matrix.
//   Clock  - sole clock, rising edge
//   Reset  - synchronous active-high reset
//   bus    - weight_loader_if slave: write strobe/data/address, Clear, read
//            port, flattened matrix, loaded flags, busy/row_done/err
module weight_loader
  import weight_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int ADDR_W = 5
) (
  input  logic            Clock,
  input  logic            Reset,
  weight_loader_if.slave  bus
);
  state_e                     state_q, state_d;
  logic   [ADDR_W-1:0]        addr_q, addr_d;
  logic   [ADDR_W-1:0]        rowc_q, rowc_d;
  logic   [ROWS-1:0][COLS-1:0] w_q;
  logic   [ROWS-1:0]          loaded_q;
  logic   [COLS-1:0]          rd_q;
  logic   [COLS-1:0]          row;
  logic                       full, shift_en, cnt_clr, addr_ok;

  weight_shift_row #(.COLS(COLS)) u_row (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .clr_i  (cnt_clr),
    .en_i   (shift_en),
    .bit_i  (bus.In),
    .row_o  (row),
    .full_o (full)
  );

  assign addr_ok = (32'(addr_q) < ROWS);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rowc_d   = rowc_q;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Clear) begin
          state_d = CLEAR;
          rowc_d  = '0;
        end else if (bus.WE) begin
          shift_en = 1'b1;
          addr_d   = bus.address;
          state_d  = full ? COMMIT : SHIFT;   // full here only when COLS==1
        end
      end
      SHIFT: begin
        if (bus.Clear) begin
          state_d = CLEAR;                     // partial row dropped
          rowc_d  = '0;
        end else if (bus.WE) begin
          shift_en = 1'b1;
          if (full) state_d = COMMIT;
        end
      end
      COMMIT: state_d = IDLE;
      CLEAR: begin
        if (32'(rowc_q) == ROWS - 1) begin
          state_d = IDLE;
          rowc_d  = '0;
        end else begin
          rowc_d = rowc_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter restarts on every entry to IDLE.
  assign cnt_clr = (state_d == IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rowc_q   <= '0;
      w_q      <= '0;
      loaded_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rowc_q  <= rowc_d;
      for (int r = 0; r < ROWS; r++) begin
        if (state_q == COMMIT && addr_ok && 32'(addr_q) == r) begin
          w_q[r]      <= row;
          loaded_q[r] <= 1'b1;
        end
        if (state_q == CLEAR && 32'(rowc_q) == r) begin
          w_q[r]      <= '0;
          loaded_q[r] <= 1'b0;
        end
      end
      // Reads see the matrix before this edge's write; out-of-range reads 0.
      rd_q <= '0;
      for (int r = 0; r < ROWS; r++)
        if (32'(bus.rd_addr) == r) rd_q <= w_q[r];
    end
  end

  assign bus.weight   = w_q;
  assign bus.loaded   = loaded_q;
  assign bus.rd_data  = rd_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.row_done = (state_q == COMMIT);
  assign bus.err      = (state_q == COMMIT) && !addr_ok;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader (ROWS=10, COLS=10).
// Row patterns are written as vectors where bit c is the c-th bit sent;
// "1010101010 first bit first" is therefore 10'h155.
module tb_weight_loader;
  localparam int ROWS = 10, COLS = 10, ADDR_W = 5;

  logic Clock, Reset;
  weight_loader_if #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) bus ();

  weight_loader #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int                   bcyc;
    int                   ndone;
    logic                 err;
    logic [ROWS*COLS-1:0] w;
    logic [ROWS-1:0]      ld;
  } exp_t;

  exp_t            expq[$];
  logic [COLS-1:0] rdq[$];
  int              checks = 0, errors = 0;

  logic [ROWS*COLS-1:0] mw;
  logic [ROWS-1:0]      mld;
  logic                 rd_req, rd_req_q;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int   bcnt, ndone;
  logic errseen, busy_prev;
  exp_t e;

  always @(posedge Clock) rd_req_q <= rd_req;

  always @(negedge Clock) begin
    if (Reset) begin
      bcnt = 0; ndone = 0; errseen = 1'b0; busy_prev = 1'b0;
    end else begin
      if (bus.busy)     bcnt++;
      if (bus.row_done) ndone++;
      if (bus.err)      errseen = 1'b1;
      if (busy_prev && !bus.busy) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_op busy fell with no expected operation");
        end else begin
          e = expq.pop_front();
          chk("busy_cycles",    128'(bcnt),  128'(e.bcyc));
          chk("row_done_count", 128'(ndone), 128'(e.ndone));
          chk("err_pulse",      128'(errseen), 128'(e.err));
          chk("weight",         128'(bus.weight), 128'(e.w));
          chk("loaded",         128'(bus.loaded), 128'(e.ld));
        end
        bcnt = 0; ndone = 0; errseen = 1'b0;
      end
      busy_prev = bus.busy;
      if (rd_req_q) begin
        if (rdq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read no expected read data");
        end else
          chk("rd_data", 128'(bus.rd_data), 128'(rdq.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50; i++) begin
      if (!bus.busy) break;
      tick();
    end
    if (i == 50) begin
      checks++; errors++;
      $display("FAIL wait_idle busy=%b expected 0 within 50 cycles", bus.busy);
    end
  endtask

  // Send a full row; the address is driven to junk after the first bit to
  // show it is latched only once.
  task automatic send_row(input int addr, input logic [COLS-1:0] bits,
                          input int gap_at, input int gap_len);
    exp_t x;
    if (addr < ROWS) begin
      mw[addr*COLS +: COLS] = bits;
      mld[addr] = 1'b1;
    end
    x.bcyc = COLS + gap_len; x.ndone = 1; x.err = (addr >= ROWS);
    x.w = mw; x.ld = mld;
    expq.push_back(x);
    for (int c = 0; c < COLS; c++) begin
      if (c == gap_at) begin
        bus.WE = 1'b0;
        repeat (gap_len) tick();
      end
      bus.WE = 1'b1; bus.In = bits[c];
      bus.address = (c == 0) ? ADDR_W'(addr) : ~ADDR_W'(addr);
      tick();
    end
    bus.WE = 1'b0; bus.In = 1'b0;
    wait_idle();
  endtask

  task automatic do_read(input int addr, input logic [COLS-1:0] exp);
    rdq.push_back(exp);
    bus.rd_addr = ADDR_W'(addr);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  initial begin
    exp_t x;
    bus.WE = 0; bus.In = 0; bus.address = '0; bus.Clear = 0; bus.rd_addr = '0;
    rd_req = 0; mw = '0; mld = '0;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;

    chk("reset_weight",   128'(bus.weight),   128'(0));
    chk("reset_loaded",   128'(bus.loaded),   128'(0));
    chk("reset_busy",     128'(bus.busy),     128'(0));
    chk("reset_row_done", 128'(bus.row_done), 128'(0));
    chk("reset_err",      128'(bus.err),      128'(0));
    chk("reset_rd_data",  128'(bus.rd_data),  128'(0));

    send_row(0, 10'h3FF, -1, 0);        // all ones to row 0
    send_row(9, 10'h155, 4, 3);         // alternating, 3-cycle gap after 4 bits
    do_read(9, 10'h155);
    do_read(12, 10'h000);               // out-of-range read
    send_row(20, 10'h0F0, -1, 0);       // out-of-range commit -> err
    send_row(3, 10'h2D3, -1, 0);

    // Clear with WE/In toggling during CLEAR
    mw = '0; mld = '0;
    x.bcyc = ROWS; x.ndone = 0; x.err = 1'b0; x.w = mw; x.ld = mld;
    expq.push_back(x);
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.WE = 1'b1; bus.In = i[0]; bus.address = ADDR_W'(4);
      tick();
    end
    bus.WE = 1'b0;
    wait_idle();
    do_read(3, 10'h000);

    // Reset in the middle of a row, then a fresh row to address 2
    for (int i = 0; i < 5; i++) begin
      bus.WE = 1'b1; bus.In = 1'b1; bus.address = ADDR_W'(5);
      tick();
    end
    bus.WE = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mw = '0; mld = '0;
    send_row(2, 10'h3C5, -1, 0);
    do_read(2, 10'h3C5);

    repeat (3) tick();
    chk("pending_expected", 128'(expq.size() + rdq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
